// File: rtl/stage_skid_reg.sv
// Purpose: valid/ready pipeline stage register with a two-entry skid buffer,
//          synchronous flush, bubble PC retention and a saturating stall counter.
// Latency: 1 cycle from accept to out_valid. Backpressure: in_ready depends on
//          state only; one extra item is absorbed after out_ready falls.
// Ports: clk/reset (async active-low); flush; in_* upstream handshake + fields;
//        out_* downstream handshake + main-slot fields; occupancy; stall_cnt.
module stage_skid_reg #(
    parameter int PAYLOAD_W        = 128,
    parameter int ADDR_W           = 5,
    parameter int CNT_W            = 16,
    parameter bit KEEP_PC_ON_FLUSH = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [31:0]          in_pc,
    input  logic [ADDR_W-1:0]    in_reg_addr,
    input  logic                 in_reg_write,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [31:0]          out_pc,
    output logic [ADDR_W-1:0]    out_reg_addr,
    output logic                 out_reg_write,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PAYLOAD_W-1:0] main_payload, skid_payload;
    logic [31:0]          main_pc, skid_pc;
    logic [ADDR_W-1:0]    main_reg_addr, skid_reg_addr;
    logic                 main_reg_write, skid_reg_write;

    logic acc, drn;
    logic load_main_in, load_skid_in, load_main_skid;
    logic [31:0] flush_pc;

    // Ready is a pure function of state so downstream stalls never reach upstream combinationally.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;
    assign occupancy = state;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_nxt    = TWO;
                        load_skid_in = 1'b1;
                    end else if (drn) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (drn) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Bubble PC after flush: the incoming PC (if any) is what an exception handler would need as EPC.
    always_comb begin
        flush_pc = 32'd0;
        if (KEEP_PC_ON_FLUSH) begin
            flush_pc = in_valid ? in_pc : main_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_payload   <= '0;
            main_pc        <= '0;
            main_reg_addr  <= '0;
            main_reg_write <= 1'b0;
            skid_payload   <= '0;
            skid_pc        <= '0;
            skid_reg_addr  <= '0;
            skid_reg_write <= 1'b0;
        end else if (flush) begin
            main_payload   <= '0;
            main_pc        <= flush_pc;
            main_reg_addr  <= '0;
            main_reg_write <= 1'b0;
            skid_payload   <= '0;
            skid_pc        <= '0;
            skid_reg_addr  <= '0;
            skid_reg_write <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_payload   <= in_payload;
                main_pc        <= in_pc;
                main_reg_addr  <= in_reg_addr;
                main_reg_write <= in_reg_write;
            end else if (load_main_skid) begin
                main_payload   <= skid_payload;
                main_pc        <= skid_pc;
                main_reg_addr  <= skid_reg_addr;
                main_reg_write <= skid_reg_write;
            end
            if (load_skid_in) begin
                skid_payload   <= in_payload;
                skid_pc        <= in_pc;
                skid_reg_addr  <= in_reg_addr;
                skid_reg_write <= in_reg_write;
            end
        end
    end

    // Counts stalled cycles for debug; survives flush, only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Main slot keeps its PC after draining, so the bubble shows a retained PC with zeroed fields.
    assign out_payload   = out_valid ? main_payload : '0;
    assign out_reg_addr  = out_valid ? main_reg_addr : '0;
    assign out_reg_write = out_valid & main_reg_write;
    assign out_pc        = main_pc;

endmodule

// File: tb/tb_stage_skid_reg.sv
// Purpose: scoreboard bench for stage_skid_reg (KEEP_PC_ON_FLUSH=1 and =0, CNT_W=4).
// Latency: expects data one cycle after accept. Backpressure: exercises skid, flush, saturation.
// Ports: drives every DUT input; two DUT instances share inputs.
module tb_stage_skid_reg;

    localparam int PW = 64;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [PW-1:0] pl;
        logic [AW-1:0] ra;
        logic          we;
    } item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic [31:0]   in_pc;
    logic [AW-1:0] in_reg_addr;
    logic          in_reg_write;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [31:0]   out_pc;
    logic [AW-1:0] out_reg_addr;
    logic          out_reg_write;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;

    logic          b_in_ready;
    logic          b_out_valid;
    logic [PW-1:0] b_out_payload;
    logic [31:0]   b_out_pc;
    logic [AW-1:0] b_out_reg_addr;
    logic          b_out_reg_write;
    logic [1:0]    b_occupancy;
    logic [CW-1:0] b_stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    item_t exp_q[$];

    always #5 clk = ~clk;

    stage_skid_reg #(.PAYLOAD_W(PW), .ADDR_W(AW), .CNT_W(CW), .KEEP_PC_ON_FLUSH(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload), .in_pc(in_pc),
        .in_reg_addr(in_reg_addr), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload), .out_pc(out_pc),
        .out_reg_addr(out_reg_addr), .out_reg_write(out_reg_write),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    stage_skid_reg #(.PAYLOAD_W(PW), .ADDR_W(AW), .CNT_W(CW), .KEEP_PC_ON_FLUSH(1'b0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_payload(in_payload), .in_pc(in_pc),
        .in_reg_addr(in_reg_addr), .in_reg_write(in_reg_write),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_payload(b_out_payload), .out_pc(b_out_pc),
        .out_reg_addr(b_out_reg_addr), .out_reg_write(b_out_reg_write),
        .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc);
        in_valid     = valid;
        in_pc        = pc;
        in_payload   = {~pc, pc};
        in_reg_addr  = pc[6:2];
        in_reg_write = pc[2];
    endtask

    // Monitor: records accepted items, checks each drained item in FIFO order,
    // and discards what flush or reset throws away. Sampled mid-cycle.
    always @(negedge clk) begin
        item_t e;
        item_t a;
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_chk++;
                a = '{pc: out_pc, pl: out_payload, ra: out_reg_addr, we: out_reg_write};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL drain_unexpected: got pc 0x%0h, expected no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_fail++;
                        $display("FAIL drain_item: got pc 0x%0h pl 0x%0h ra %0d we %0b, expected pc 0x%0h pl 0x%0h ra %0d we %0b",
                                 a.pc, a.pl, a.ra, a.we, e.pc, e.pl, e.ra, e.we);
                    end
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back('{pc: in_pc, pl: in_payload, ra: in_reg_addr, we: in_reg_write});
            end
        end
    end

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0);

        // Reset values while reset is held
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_payload", 64'(out_payload), 64'd0);
        check("rst_reg_addr_we", 64'({out_reg_addr, out_reg_write}), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming: 6 items back to back, each visible one cycle after accept
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i));
            step();
            check("stream_pc", 64'(out_pc), 64'h3000 + 64'(4 * i));
            check("stream_occ", 64'(occupancy), 64'd1);
        end
        drive(1'b0, 32'd0);
        step();
        check("stream_empty_occ", 64'(occupancy), 64'd0);
        check("stream_bubble_pc", 64'(out_pc), 64'h3014);
        check("stream_bubble_payload", 64'(out_payload), 64'd0);
        check("stream_stall_cnt", 64'(stall_cnt), 64'd0);

        // Back-pressure: A in main, then 3 stalled cycles with in_valid held
        drive(1'b1, 32'h3100);
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h3104);
        step();
        check("bp_occ_two", 64'(occupancy), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h3108);
        step();
        step();
        check("bp_stall_cnt3", 64'(stall_cnt), 64'd3);
        check("bp_in_ready_still_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        check("bp_release_occ", 64'(occupancy), 64'd1);
        check("bp_release_pc", 64'(out_pc), 64'h3104);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_third_pc", 64'(out_pc), 64'h3108);
        drive(1'b0, 32'd0);
        step();
        check("bp_drained_occ", 64'(occupancy), 64'd0);

        // Flush in TWO with an incoming PC
        out_ready = 1'b0;
        drive(1'b1, 32'h3200);
        step();
        drive(1'b1, 32'h3204);
        step();
        check("fl2_occ_two", 64'(occupancy), 64'd2);
        flush = 1'b1;
        drive(1'b1, 32'h3010);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0);
        check("fl2_occ", 64'(occupancy), 64'd0);
        check("fl2_out_valid", 64'(out_valid), 64'd0);
        check("fl2_reg_write", 64'(out_reg_write), 64'd0);
        check("fl2_payload", 64'(out_payload), 64'd0);
        check("fl2_pc_keep", 64'(out_pc), 64'h3010);
        check("fl2_pc_nokeep", 64'(b_out_pc), 64'd0);
        check("fl2_occ_nokeep", 64'(b_occupancy), 64'd0);
        check("fl2_stall_cnt", 64'(stall_cnt), 64'd5);

        // Accept + drain in ONE, then the same with flush
        out_ready = 1'b1;
        drive(1'b1, 32'h3300);
        step();
        drive(1'b1, 32'h3304);
        step();
        check("ad_occ", 64'(occupancy), 64'd1);
        check("ad_pc", 64'(out_pc), 64'h3304);
        flush = 1'b1;
        drive(1'b1, 32'h3308);
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0);
        check("adf_occ", 64'(occupancy), 64'd0);
        check("adf_out_valid", 64'(out_valid), 64'd0);
        check("adf_pc", 64'(out_pc), 64'h3308);
        step();
        check("adf_still_empty", 64'(occupancy), 64'd0);
        check("adf_pc_retained", 64'(out_pc), 64'h3308);

        // Stall counter saturation (starts at 5)
        out_ready = 1'b0;
        drive(1'b1, 32'h3400);
        step();
        drive(1'b0, 32'd0);
        repeat (5) step();
        check("sat_mid", 64'(stall_cnt), 64'd10);
        repeat (15) step();
        check("sat_15", 64'(stall_cnt), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("sat_after_flush", 64'(stall_cnt), 64'd15);
        check("sat_flush_occ", 64'(occupancy), 64'd0);

        // Asynchronous reset pulse mid-cycle while holding an item
        drive(1'b1, 32'h3500);
        step();
        drive(1'b0, 32'd0);
        check("ar_pre_occ", 64'(occupancy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_stall_cnt", 64'(stall_cnt), 64'd0);
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_occ", 64'(occupancy), 64'd0);
        check("ar_out_pc", 64'(out_pc), 64'd0);
        check("ar_payload", 64'(out_payload), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        #2;
        reset = 1'b1;
        step();
        check("ar_after_release", 64'(out_valid), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/stage_skid_reg.md
# stage_skid_reg

Parametrised successor to the fixed-field inter-stage pipeline register. It is a valid/ready pipeline stage register with a two-entry skid buffer, synchronous flush, and PC preservation on bubbles. It sits between any two pipeline stages (e.g. E→M, M→W), so downstream back-pressure never forms a combinational path upstream. A saturating stall counter exposes back-pressure for debug.

## Interface
Parameters:
- PAYLOAD_W, 128: width of the opaque payload bus (instr, PC+8, ALU result, RD2, … packed by the instantiating stage)
- ADDR_W, 5: destination register address width
- CNT_W, 16: stall counter width
- KEEP_PC_ON_FLUSH, 1: 1 = bubbles carry a valid PC for EPC use; 0 = bubble PC is 0

Ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge
- reset, in, 1: asynchronous, active-low reset
- flush, in, 1: synchronous clear of both slots
- in_valid, in, 1: upstream has data
- in_ready, out, 1: stage can accept
- in_payload, in, PAYLOAD_W: upstream payload
- in_pc, in, 32: upstream PC
- in_reg_addr, in, ADDR_W: destination register
- in_reg_write, in, 1: register-write enable
- out_valid, out, 1: main slot holds valid data
- out_ready, in, 1: downstream accepts
- out_payload, out, PAYLOAD_W: main-slot payload
- out_pc, out, 32: main-slot PC (or preserved bubble PC)
- out_reg_addr, out, ADDR_W: main-slot destination register
- out_reg_write, out, 1: main-slot reg_write AND out_valid
- occupancy, out, 2: entries held (0, 1, 2)
- stall_cnt, out, CNT_W: saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main slot (drives outputs) and skid slot. Each slot holds payload, pc, reg_addr, reg_write.
- State: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full).
- acc = in_valid & in_ready; drn = out_valid & out_ready.
- in_ready = (state != TWO). It is a function of state only, with no path from out_ready.
- Transitions, when flush=0:
  - EMPTY: acc → ONE, main ← in.
  - ONE: acc & drn → ONE, main ← in. acc & !drn → TWO, skid ← in. !acc & drn → EMPTY. Otherwise hold.
  - TWO: drn → ONE, main ← skid. Otherwise hold. No accept is possible in TWO.
- Flush has the highest priority:
  - Next state is EMPTY. Payload, reg_addr and reg_write of both slots are cleared.
  - A same-cycle accepted input is discarded. A same-cycle drain completes downstream normally.
  - With KEEP_PC_ON_FLUSH=1, the main pc takes in_pc if in_valid=1, else it holds its current value. With KEEP_PC_ON_FLUSH=0, the main pc becomes 0.
- In EMPTY:
  - out_payload and out_reg_addr are 0 and out_reg_write is 0.
  - out_pc shows the retained pc, so forwarding and hazard logic see a clean bubble.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready and saturates at 2^CNT_W−1.
  - It is cleared only by reset. Flush does not clear it.

## Timing
- Reset (reset=0, asynchronous): state EMPTY; all slot contents 0; stall_cnt 0. Outputs during and after reset: out_valid 0, in_ready 1, occupancy 0, out_pc 0, out_payload 0, out_reg_addr 0, out_reg_write 0.
- Latency: data accepted at edge N appears on the outputs after edge N (out_valid=1 in cycle N+1) when the stage was EMPTY or draining.
- Throughput: 1 transfer per cycle while out_ready=1 continuously.
- Skid: after out_ready falls, one more item is still absorbed (ONE→TWO) and in_ready drops the cycle after.
- Order is strictly FIFO. No item is duplicated or lost except by flush.
- Reset asserted mid-transfer returns the stage to EMPTY immediately. Release is synchronous to the next edge.

## Test plan
- Reset then stream: 6 back-to-back items, in_pc 0x3000, 0x3004, …, out_ready=1 → out_pc 0x3000.. in order, one cycle after each accept, occupancy ≤1, stall_cnt=0.
- Back-pressure: out_ready=0 for 3 cycles while in_valid=1 → occupancy 1→2, in_ready=0 from the 2nd stall cycle, stall_cnt=3. On release, both items drain in order and no input is lost.
- Flush in TWO with in_valid=1 and in_pc=0x3010 → next cycle: occupancy 0, out_valid 0, out_reg_write 0, out_payload 0, out_pc 0x3010. Repeat with KEEP_PC_ON_FLUSH=0 → out_pc 0.
- Simultaneous accept and drain in ONE → occupancy stays 1 and out shows the new item. Flush in the same cycle → EMPTY and the input is discarded.
- Saturation with CNT_W=4: out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15 and holds. Flush leaves it at 15. Async reset pulse mid-cycle → stall_cnt 0 and all outputs 0 before the next edge.
